// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: EX-stage ALU control decoder with a multi-cycle multiply/divide
// sequencer, architectural HI/LO registers and a pipeline stall request.
// Decode is purely combinational. The MD sequencer runs one shift-add or
// restoring shift-subtract step per cycle on operand magnitudes and applies
// the sign fix-up in the DONE cycle, when HI/LO are written.

module alu_ctrl_md #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      iALUOp,
    input  logic [5:0]      iIR_func,
    input  logic [5:0]      iIR_op,
    input  logic            iValid,
    input  logic            iFlush,
    input  logic [XLEN-1:0] iRs,
    input  logic [XLEN-1:0] iRt,
    output logic [3:0]      oALUctrl,
    output logic            oJR,
    output logic            oStall,
    output logic            oMDSel,
    output logic [XLEN-1:0] oMDResult,
    output logic [XLEN-1:0] oHI,
    output logic [XLEN-1:0] oLO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // R-type funct field to ALU op code; unknown functs fall back to add.
    function automatic logic [3:0] dec_rtype(input logic [5:0] f);
        logic [3:0] c;
        case (f)
            6'b100000: c = 4'd0;   // add
            6'b100010: c = 4'd1;   // sub
            6'b100100: c = 4'd2;   // and
            6'b100101: c = 4'd3;   // or
            6'b101010: c = 4'd4;   // slt
            6'b100110: c = 4'd5;   // xor
            6'b100111: c = 4'd6;   // nor
            6'b000000: c = 4'd7;   // sll
            6'b000010: c = 4'd8;   // srl
            6'b000011: c = 4'd9;   // sra
            default:   c = 4'd0;
        endcase
        return c;
    endfunction

    // I-type opcode to ALU op code; unknown opcodes fall back to add.
    function automatic logic [3:0] dec_itype(input logic [5:0] op);
        logic [3:0] c;
        case (op)
            6'b001000: c = 4'd0;   // addi
            6'b001100: c = 4'd2;   // andi
            6'b001101: c = 4'd3;   // ori
            6'b001010: c = 4'd4;   // slti
            6'b001110: c = 4'd5;   // xori
            default:   c = 4'd0;
        endcase
        return c;
    endfunction

    // Conditional two's-complement negation at datapath width.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Conditional two's-complement negation of a double-width product.
    function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_hi;         // architectural HI
    logic [XLEN-1:0]    r_lo;         // architectural LO
    logic [XLEN-1:0]    r_hi_acc;     // product high half / partial remainder
    logic [XLEN-1:0]    r_lo_acc;     // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0]    r_opnd;       // multiplicand magnitude / divisor magnitude
    logic               r_is_div;
    logic               r_neg_lo;     // negate product or quotient at the end
    logic               r_neg_hi;     // negate remainder at the end (dividend sign)
    logic               r_div0;       // divisor was zero

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    logic w_rtype;
    logic w_mult, w_multu, w_div, w_divu, w_mfhi, w_mflo;
    logic w_md_op, w_signed_op, w_mfx_v, w_start;
    logic w_idle, w_busy;

    assign w_rtype     = (iALUOp == 2'b01);
    assign w_mult      = w_rtype && (iIR_func == 6'b011000);
    assign w_multu     = w_rtype && (iIR_func == 6'b011001);
    assign w_div       = w_rtype && (iIR_func == 6'b011010);
    assign w_divu      = w_rtype && (iIR_func == 6'b011011);
    assign w_mfhi      = w_rtype && (iIR_func == 6'b010000);
    assign w_mflo      = w_rtype && (iIR_func == 6'b010010);
    assign w_md_op     = w_mult | w_multu | w_div | w_divu;
    assign w_signed_op = w_mult | w_div;
    assign w_mfx_v     = iValid & (w_mfhi | w_mflo);

    assign w_idle      = (r_state == S_IDLE);
    assign w_busy      = (r_state == S_BUSY);

    // Start is masked while reset is held so a still-presented MD op cannot
    // raise the stall during an asynchronous clear.
    assign w_start     = rst_n & iValid & w_md_op & ~iFlush & w_idle;

    // Decode: ALU op code from ALUOp class and funct/opcode fields
    always_comb begin
        oALUctrl = 4'd0;
        case (iALUOp)
            2'b00:   oALUctrl = 4'd0;
            2'b10:   oALUctrl = 4'd1;
            2'b01:   oALUctrl = dec_rtype(iIR_func);
            2'b11:   oALUctrl = dec_itype(iIR_op);
            default: oALUctrl = 4'd0;
        endcase
    end

    assign oJR = w_rtype && (iIR_func == 6'b001000);

    // ------------------------------------------------------------------
    // Operand magnitudes captured at start
    // ------------------------------------------------------------------
    logic            w_rs_neg, w_rt_neg;
    logic [XLEN-1:0] w_rs_mag, w_rt_mag;

    assign w_rs_neg = w_signed_op & iRs[XLEN-1];
    assign w_rt_neg = w_signed_op & iRt[XLEN-1];
    assign w_rs_mag = neg_if(iRs, w_rs_neg);
    assign w_rt_mag = neg_if(iRt, w_rt_neg);

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift {carry, sum, multiplier} right by one.
    logic [XLEN:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. If the shifted-out bit is set the
    // divisor always fits, and the low XLEN bits of the difference are exact.
    logic [XLEN:0]   w_div_shift;
    logic [XLEN-1:0] w_div_diff;
    logic            w_div_ge;
    assign w_div_shift = {r_hi_acc, r_lo_acc[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_opnd;

    // ------------------------------------------------------------------
    // Sign fix-up for the DONE cycle
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fin_hi, w_fin_lo;

    assign w_prod   = neg_if2({r_hi_acc, r_lo_acc}, r_neg_lo);
    // Divide by zero leaves the dividend magnitude as remainder; restoring its
    // sign gives back the original dividend, and the quotient is forced to ones.
    assign w_quo    = r_div0 ? {XLEN{1'b1}} : neg_if(r_lo_acc, r_neg_lo);
    assign w_rem    = neg_if(r_hi_acc, r_neg_hi);
    assign w_fin_hi = r_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
    assign w_fin_lo = r_is_div ? w_quo : w_prod[XLEN-1:0];

    // MD sequencer FSM: start/latch, iterate, write HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_is_div <= w_div | w_divu;
                        r_neg_lo <= w_rs_neg ^ w_rt_neg;
                        r_neg_hi <= w_rs_neg;
                        r_div0   <= (iRt == '0);
                        r_hi_acc <= '0;
                        if (w_div | w_divu) begin
                            r_lo_acc <= w_rs_mag;
                            r_opnd   <= w_rt_mag;
                        end else begin
                            r_lo_acc <= w_rt_mag;
                            r_opnd   <= w_rs_mag;
                        end
                        r_cnt    <= CNT_W'(XLEN);
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (iFlush) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_hi_acc <= w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
                            r_lo_acc <= {r_lo_acc[XLEN-2:0], w_div_ge};
                        end else begin
                            r_hi_acc <= w_mul_sum[XLEN:1];
                            r_lo_acc <= {w_mul_sum[0], r_lo_acc[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_hi    <= w_fin_hi;
                    r_lo    <= w_fin_lo;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pipeline-facing outputs
    // ------------------------------------------------------------------
    // mfhi/mflo seen outside IDLE must wait for the pending HI/LO write.
    assign oStall    = w_start | w_busy | (w_mfx_v & ~w_idle);
    assign oMDSel    = w_mfx_v & w_idle;
    assign oMDResult = oMDSel ? (w_mfhi ? r_hi : r_lo) : '0;
    assign oHI       = r_hi;
    assign oLO       = r_lo;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: directed self-checking bench for alu_ctrl_md.
// Decode sweep, multiply/divide results and stall length, mflo behind an MD op,
// flush abort and asynchronous reset mid-operation.

module tb_alu_ctrl_md;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      iALUOp;
    logic [5:0]      iIR_func;
    logic [5:0]      iIR_op;
    logic            iValid;
    logic            iFlush;
    logic [XLEN-1:0] iRs;
    logic [XLEN-1:0] iRt;
    logic [3:0]      oALUctrl;
    logic            oJR;
    logic            oStall;
    logic            oMDSel;
    logic [XLEN-1:0] oMDResult;
    logic [XLEN-1:0] oHI;
    logic [XLEN-1:0] oLO;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    alu_ctrl_md #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iALUOp    (iALUOp),
        .iIR_func  (iIR_func),
        .iIR_op    (iIR_op),
        .iValid    (iValid),
        .iFlush    (iFlush),
        .iRs       (iRs),
        .iRt       (iRt),
        .oALUctrl  (oALUctrl),
        .oJR       (oJR),
        .oStall    (oStall),
        .oMDSel    (oMDSel),
        .oMDResult (oMDResult),
        .oHI       (oHI),
        .oLO       (oLO)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input string tag, input logic [1:0] aop, input logic [5:0] f,
                       input logic [5:0] op, input logic [3:0] exp);
        iValid = 1'b0; iALUOp = aop; iIR_func = f; iIR_op = op;
        #1;
        chk(tag, {28'd0, oALUctrl}, {28'd0, exp});
    endtask

    // Present an MD op, count stall cycles (bounded), drop it in DONE, and
    // advance into IDLE where HI/LO hold the result.
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cnt);
        iALUOp = 2'b01; iIR_func = f; iRs = a; iRt = b; iValid = 1'b1;
        cnt = 0;
        #1;
        while (oStall && cnt < 60) begin
            cnt++;
            step();
        end
        iValid = 1'b0; iIR_func = 6'd0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; iALUOp = 2'b00; iIR_func = 6'd0; iIR_op = 6'd0;
        iValid = 1'b0; iFlush = 1'b0; iRs = '0; iRt = '0;
        #2;
        chk("rst_hi", oHI, 32'h0);
        chk("rst_lo", oLO, 32'h0);
        chk("rst_stall", {31'd0, oStall}, 32'd0);
        chk("rst_mdsel", {31'd0, oMDSel}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Decode sweep
        dec("dec_00",      2'b00, 6'b100111, 6'b001100, 4'd0);
        dec("dec_10",      2'b10, 6'b100000, 6'b001100, 4'd1);
        dec("dec_r_add",   2'b01, 6'b100000, 6'b001100, 4'd0);
        dec("dec_r_sub",   2'b01, 6'b100010, 6'b001100, 4'd1);
        dec("dec_r_and",   2'b01, 6'b100100, 6'b000000, 4'd2);
        dec("dec_r_or",    2'b01, 6'b100101, 6'b000000, 4'd3);
        dec("dec_r_slt",   2'b01, 6'b101010, 6'b000000, 4'd4);
        dec("dec_r_xor",   2'b01, 6'b100110, 6'b000000, 4'd5);
        dec("dec_r_nor",   2'b01, 6'b100111, 6'b000000, 4'd6);
        dec("dec_r_sll",   2'b01, 6'b000000, 6'b001101, 4'd7);
        dec("dec_r_srl",   2'b01, 6'b000010, 6'b000000, 4'd8);
        dec("dec_r_sra",   2'b01, 6'b000011, 6'b000000, 4'd9);
        dec("dec_r_other", 2'b01, 6'b111111, 6'b001101, 4'd0);
        dec("dec_i_addi",  2'b11, 6'b100111, 6'b001000, 4'd0);
        dec("dec_i_andi",  2'b11, 6'b100111, 6'b001100, 4'd2);
        dec("dec_i_ori",   2'b11, 6'b000000, 6'b001101, 4'd3);
        dec("dec_i_slti",  2'b11, 6'b000000, 6'b001010, 4'd4);
        dec("dec_i_xori",  2'b11, 6'b000000, 6'b001110, 4'd5);
        dec("dec_i_other", 2'b11, 6'b100111, 6'b000100, 4'd0);
        dec("dec_jr_ctrl", 2'b01, 6'b001000, 6'b000000, 4'd0);
        chk("jr_set", {31'd0, oJR}, 32'd1);
        dec("dec_jr_itype", 2'b11, 6'b001000, 6'b001100, 4'd2);
        chk("jr_clear_itype", {31'd0, oJR}, 32'd0);
        chk("dec_no_stall", {31'd0, oStall}, 32'd0);

        // mult -7 x 3
        step();
        run_md(6'b011000, 32'hFFFF_FFF9, 32'd3, n);
        chk("mult_stall_len", n, 32'd33);
        chk("mult_hi", oHI, 32'hFFFF_FFFF);
        chk("mult_lo", oLO, 32'hFFFF_FFEB);

        // multu FFFFFFFF x 2
        run_md(6'b011001, 32'hFFFF_FFFF, 32'd2, n);
        chk("multu_stall_len", n, 32'd33);
        chk("multu_hi", oHI, 32'h0000_0001);
        chk("multu_lo", oLO, 32'hFFFF_FFFE);

        // mfhi / mflo in IDLE return HI/LO the same cycle
        iALUOp = 2'b01; iIR_func = 6'b010000; iValid = 1'b1;
        #1;
        chk("mfhi_sel", {31'd0, oMDSel}, 32'd1);
        chk("mfhi_val", oMDResult, 32'h0000_0001);
        chk("mfhi_nostall", {31'd0, oStall}, 32'd0);
        iIR_func = 6'b010010;
        #1;
        chk("mflo_val", oMDResult, 32'hFFFF_FFFE);
        iValid = 1'b0;
        #1;
        chk("mflo_invalid_sel", {31'd0, oMDSel}, 32'd0);
        chk("mflo_invalid_res", oMDResult, 32'h0);
        step();

        // div -7 / 2
        run_md(6'b011010, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_stall_len", n, 32'd33);
        chk("div_lo", oLO, 32'hFFFF_FFFD);
        chk("div_hi", oHI, 32'hFFFF_FFFF);

        // divu 7 / 0
        run_md(6'b011011, 32'd7, 32'd0, n);
        chk("divu0_lo", oLO, 32'hFFFF_FFFF);
        chk("divu0_hi", oHI, 32'h0000_0007);

        // signed div by zero returns the dividend in HI
        run_md(6'b011010, 32'hFFFF_FFFB, 32'd0, n);
        chk("div0_lo", oLO, 32'hFFFF_FFFF);
        chk("div0_hi", oHI, 32'hFFFF_FFFB);

        // most-negative / -1
        run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divovf_lo", oLO, 32'h8000_0000);
        chk("divovf_hi", oHI, 32'h0000_0000);

        // divu 100 / 7
        run_md(6'b011011, 32'd100, 32'd7, n);
        chk("divu_lo", oLO, 32'd14);
        chk("divu_hi", oHI, 32'd2);

        // mflo back-to-back behind mult 5 x 6
        iALUOp = 2'b01; iIR_func = 6'b011000; iRs = 32'd5; iRt = 32'd6; iValid = 1'b1;
        n = 0;
        #1;
        while (oStall && n < 60) begin
            n++;
            step();
        end
        chk("mul56_stall_len", n, 32'd33);
        iIR_func = 6'b010010;
        #1;
        chk("mflo_done_stall", {31'd0, oStall}, 32'd1);
        chk("mflo_done_sel", {31'd0, oMDSel}, 32'd0);
        step();
        chk("mflo_after_sel", {31'd0, oMDSel}, 32'd1);
        chk("mflo_after_val", oMDResult, 32'h0000_001E);
        chk("mflo_after_stall", {31'd0, oStall}, 32'd0);
        iValid = 1'b0; iIR_func = 6'd0;
        step();

        // flush at BUSY cycle 10 of div
        iALUOp = 2'b01; iIR_func = 6'b011010; iRs = 32'd100; iRt = 32'd7; iValid = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        chk("flush_busy_stall", {31'd0, oStall}, 32'd1);
        iFlush = 1'b1;
        step();
        chk("flush_stall", {31'd0, oStall}, 32'd0);
        iFlush = 1'b0; iValid = 1'b0; iIR_func = 6'd0;
        for (int i = 0; i < 40; i++) step();
        chk("flush_hi", oHI, 32'h0000_0000);
        chk("flush_lo", oLO, 32'h0000_001E);

        // async reset at BUSY cycle 5 of mult
        iALUOp = 2'b01; iIR_func = 6'b011000; iRs = 32'd9; iRt = 32'd9; iValid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("arst_busy_stall", {31'd0, oStall}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", {31'd0, oStall}, 32'd0);
        chk("arst_hi", oHI, 32'h0);
        chk("arst_lo", oLO, 32'h0);
        iValid = 1'b0; iIR_func = 6'd0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("arst_after_lo", oLO, 32'h0);
        chk("arst_after_stall", {31'd0, oStall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
